// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register: DEPTH stages of write-back payload with stall/flush and forwarding lookups.
// Latency DEPTH cycles (+1 per stalled cycle); stall holds every stage and the upstream stage must hold its entry.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int DEPTH  = 1,
    parameter int NQ     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [REG_W-1:0]       in_rd,
    input  logic                   in_regwrite,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [REG_W-1:0]       out_rd,
    output logic                   out_regwrite,
    input  logic [NQ*REG_W-1:0]    fwd_addr,
    output logic [NQ-1:0]          fwd_hit,
    output logic [NQ*DATA_W-1:0]   fwd_data,
    output logic [15:0]            stall_cycles
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
    } stage_t;

    // Index 0 is the youngest entry, DEPTH-1 the one presented to the register file.
    stage_t stg [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else if (!stall) begin
            if (flush) begin
                stg[0] <= '0;
            end else begin
                stg[0] <= '{valid: in_valid, data: in_data, rd: in_rd, regwrite: in_regwrite};
            end
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end else if (flush) begin
            // Stalled flush kills the youngest entry in place; its payload is left as-is.
            stg[0].valid    <= 1'b0;
            stg[0].regwrite <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

    assign out_valid    = stg[DEPTH-1].valid;
    assign out_data     = stg[DEPTH-1].data;
    assign out_rd       = stg[DEPTH-1].rd;
    assign out_regwrite = stg[DEPTH-1].valid & stg[DEPTH-1].regwrite & (stg[DEPTH-1].rd != '0);

    // Scan oldest to youngest so the youngest matching stage is the last to overwrite the result.
    always_comb begin
        fwd_hit  = '0;
        fwd_data = '0;
        for (int q = 0; q < NQ; q++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (stg[i].valid && stg[i].regwrite && (stg[i].rd != '0) &&
                    (stg[i].rd == fwd_addr[q*REG_W +: REG_W])) begin
                    fwd_hit[q]                  = 1'b1;
                    fwd_data[q*DATA_W +: DATA_W] = stg[i].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Drives four pipes (DEPTH 1..4) in lockstep and scores them against a shared history of entries.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        stall;
    logic        flush;
    logic [9:0]  fwd_addr;

    logic        ov  [4];
    logic [31:0] od  [4];
    logic [4:0]  ord [4];
    logic        orw [4];
    logic [1:0]  fh  [4];
    logic [63:0] fd  [4];
    logic [15:0] sc  [4];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [4:0]  rd;
        logic        rw;
    } ent_t;

    // Newest entry at the back; hist[3] is stage 0, hist[3-g] is the last stage of the DEPTH=g+1 pipe.
    ent_t        hist [$];
    logic [15:0] scnt;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_wb_pipe #(.DATA_W(32), .REG_W(5), .DEPTH(g + 1), .NQ(2)) dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid),
            .in_data      (in_data),
            .in_rd        (in_rd),
            .in_regwrite  (in_regwrite),
            .stall        (stall),
            .flush        (flush),
            .out_valid    (ov[g]),
            .out_data     (od[g]),
            .out_rd       (ord[g]),
            .out_regwrite (orw[g]),
            .fwd_addr     (fwd_addr),
            .fwd_hit      (fh[g]),
            .fwd_data     (fd[g]),
            .stall_cycles (sc[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [31:0] d, input logic [4:0] rd,
                        input logic rw, input logic st, input logic fl);
        ent_t e;
        reset = rst; in_valid = v; in_data = d; in_rd = rd; in_regwrite = rw;
        stall = st; flush = fl;
        @(posedge clk);
        if (rst) begin
            hist.delete();
            for (int i = 0; i < 4; i++) hist.push_back('{1'b0, 32'h0, 5'h0, 1'b0});
            scnt = 16'h0;
        end else begin
            if (st) begin
                if (scnt != 16'hFFFF) scnt = scnt + 16'd1;
                if (fl) begin
                    hist[3].v  = 1'b0;
                    hist[3].rw = 1'b0;
                end
            end else begin
                e = fl ? '{1'b0, 32'h0, 5'h0, 1'b0} : '{v, d, rd, rw};
                hist.push_back(e);
                void'(hist.pop_front());
            end
        end
        #1;
    endtask

    task automatic check_all();
        ent_t        e;
        logic [4:0]  addr;
        logic        eh;
        logic [31:0] ed;
        for (int g = 0; g < 4; g++) begin
            e = hist[3-g];
            check($sformatf("d%0d out_valid", g + 1), 64'(ov[g]), 64'(e.v));
            check($sformatf("d%0d out_data", g + 1), 64'(od[g]), 64'(e.d));
            check($sformatf("d%0d out_rd", g + 1), 64'(ord[g]), 64'(e.rd));
            check($sformatf("d%0d out_regwrite", g + 1), 64'(orw[g]), 64'(e.v & e.rw & (e.rd != 5'd0)));
            for (int q = 0; q < 2; q++) begin
                addr = fwd_addr[q*5 +: 5];
                eh = 1'b0;
                ed = 32'h0;
                for (int i = 3; i >= 3 - g; i--) begin
                    if (hist[i].v && hist[i].rw && hist[i].rd != 5'd0 && hist[i].rd == addr) begin
                        eh = 1'b1;
                        ed = hist[i].d;
                        break;
                    end
                end
                check($sformatf("d%0d fwd_hit[%0d]", g + 1, q), 64'(fh[g][q]), 64'(eh));
                check($sformatf("d%0d fwd_data[%0d]", g + 1, q), 64'(fd[g][q*32 +: 32]), 64'(ed));
            end
            check($sformatf("d%0d stall_cycles", g + 1), 64'(sc[g]), 64'(scnt));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fwd_addr = '0;
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check_all();
        for (int g = 0; g < 4; g++) begin
            check("reset out_regwrite", 64'(orw[g]), 64'd0);
            check("reset stall_cycles", 64'(sc[g]), 64'd0);
        end

        // Single write through the DEPTH=1 pipe.
        fwd_addr = {5'd0, 5'd8};
        step(0, 1, 32'h12345678, 5'd8, 1, 0, 0);
        check_all();
        check("d1 stream data", 64'(od[0]), 64'h12345678);
        check("d1 stream rd", 64'(ord[0]), 64'd8);
        check("d1 stream regwrite", 64'(orw[0]), 64'd1);
        check("d1 stream valid", 64'(ov[0]), 64'd1);
        check("d1 fwd rd8", 64'(fh[0]), 64'b01);

        // A write to $zero is carried but never strobes or forwards.
        fwd_addr = {5'd0, 5'd0};
        step(0, 1, 32'hDEADBEEF, 5'd0, 1, 0, 0);
        check_all();
        check("zero valid", 64'(ov[0]), 64'd1);
        check("zero regwrite", 64'(orw[0]), 64'd0);
        check("zero fwd_hit", 64'(fh[0]), 64'd0);
        check("zero fwd_data", fd[0], 64'd0);

        // Stall then flush on the DEPTH=3 pipe.
        step(1, 0, 0, 0, 0, 0, 0);
        fwd_addr = {5'd3, 5'd1};
        step(0, 1, 32'hA, 5'd1, 1, 0, 0);
        step(0, 1, 32'hB, 5'd2, 1, 0, 0);
        step(0, 1, 32'hC, 5'd3, 1, 0, 0);
        check_all();
        check("d3 A at output", 64'(ord[2]), 64'd1);
        step(0, 1, 32'hD, 5'd4, 1, 1, 0);
        step(0, 1, 32'hD, 5'd4, 1, 1, 0);
        check_all();
        check("d3 stall held rd", 64'(ord[2]), 64'd1);
        check("d3 stall held data", 64'(od[2]), 64'hA);
        check("d3 stall_cycles", 64'(sc[2]), 64'd2);
        check("d3 fwd C during stall", 64'(fd[2][63:32]), 64'hC);
        step(0, 1, 32'hD, 5'd4, 1, 0, 1);
        check_all();
        check("d3 after flush rd", 64'(ord[2]), 64'd2);
        check("d1 flush bubble", 64'(ov[0]), 64'd0);

        // Stall+flush kills the youngest entry in place.
        fwd_addr = {5'd3, 5'd7};
        step(0, 1, 32'hE, 5'd7, 1, 0, 0);
        step(0, 1, 32'hF, 5'd9, 1, 1, 1);
        check_all();
        check("d1 killed valid", 64'(ov[0]), 64'd0);
        check("d1 killed data held", 64'(od[0]), 64'hE);
        check("d3 killed no fwd", 64'(fh[2][0]), 64'd0);

        // Forwarding priority on DEPTH=2.
        fwd_addr = {5'd6, 5'd5};
        step(0, 1, 32'h11, 5'd5, 1, 0, 0);
        step(0, 1, 32'h22, 5'd5, 1, 0, 0);
        check_all();
        check("d2 fwd youngest hit", 64'(fh[1]), 64'b01);
        check("d2 fwd youngest data", fd[1], 64'h0000_0000_0000_0022);

        // Randomised traffic with occasional stall/flush.
        for (int n = 0; n < 300; n++) begin
            fwd_addr = 10'($urandom_range(0, 1023)) & 10'b00111_00111;
            step(0, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
            check_all();
        end

        // Counter saturation.
        for (int n = 0; n < 70000; n++) step(0, 0, 0, 0, 0, 1, 0);
        check_all();
        for (int g = 0; g < 4; g++) check("stall_cycles saturated", 64'(sc[g]), 64'hFFFF);

        // Reset in the middle of a full pipe.
        fwd_addr = {5'd2, 5'd1};
        for (int n = 1; n <= 4; n++) step(0, 1, 32'h100 + 32'(n), 5'(n), 1, 0, 0);
        check_all();
        check("d4 full valid", 64'(ov[3]), 64'd1);
        step(1, 1, 32'h999, 5'd1, 1, 1, 1);
        check_all();
        for (int g = 0; g < 4; g++) begin
            check("mid reset out_valid", 64'(ov[g]), 64'd0);
            check("mid reset out_regwrite", 64'(orw[g]), 64'd0);
            check("mid reset out_data", 64'(od[g]), 64'd0);
            check("mid reset fwd_hit", 64'(fh[g]), 64'd0);
            check("mid reset stall_cycles", 64'(sc[g]), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
